datamem_lanes: RTL and testbench
================================

Name: datamem_lanes

Overview:
- Parametrised successor to the pipeline's data memory.
- Byte-lane stores for SB/SH/SW (plus SD when DATA_W=64).
- Full RISC-V load extension: LB/LH/LW/LBU/LHU, plus LWU/LD when DATA_W=64.
- Registered read data with a valid strobe; one-cycle alignment and illegal-op flags.
- Sits in the MEM stage and is addressed by the low DM_ADDRESS bits of the ALU result.

Parameters:
DM_ADDRESS, 9, byte-address width; memory holds 2^DM_ADDRESS bytes.
DATA_W, 32, word width; legal values 32 or 64. NB = DATA_W/8 lanes; OFF = log2(NB) offset bits.

Ports:
clk  in  1  clock; all state updates on posedge.
rst_n  in  1  asynchronous active-low reset.
MemRead  in  1  load request this cycle (from control unit).
MemWrite  in  1  store request this cycle (from control unit).
a  in  DM_ADDRESS  byte address.
wd  in  DATA_W  store data, right-aligned (SB uses wd[7:0], SH uses wd[15:0], etc.).
Funct3  in  3  instruction bits 14:12.
rd  out  DATA_W  extended load result, registered.
rd_valid  out  1  one-cycle pulse: rd was updated by a completed load.
misaligned  out  1  one-cycle pulse: the access was rejected for alignment.
illegal  out  1  one-cycle pulse: the access was rejected for an unsupported Funct3.

Behaviour:
- Reset: rd=0, rd_valid=0, misaligned=0, illegal=0, applied asynchronously on rst_n low.
- The array is not reset; contents are undefined until written.
- While rst_n is low, no write occurs.
- Geometry: word index = a[DM_ADDRESS-1:OFF]; lane offset = a[OFF-1:0]. DEPTH = 2^(DM_ADDRESS-OFF) words of NB byte-enabled lanes.
- Priority: MemWrite=1 takes precedence; a simultaneous MemRead is ignored and rd_valid stays 0.
- Store size by Funct3:
  - 000 → 1 byte.
  - 001 → 2 bytes.
  - 010 → 4 bytes.
  - 011 → 8 bytes (DATA_W=64 only).
  - Any other value → illegal.
- Store write: data is shifted left by offset*8, and byte enables cover lanes offset .. offset+size-1. The write completes at the posedge of the request cycle; other lanes are unchanged.
- Load by Funct3:
  - 000 LB: sign-extended.
  - 001 LH: sign-extended.
  - 010 LW: sign-extended to DATA_W.
  - 100 LBU: zero-extended.
  - 101 LHU: zero-extended.
  - 110 LWU: zero-extended; DATA_W=64 only.
  - 011 LD: DATA_W=64 only.
  - 111, or a 64-only code with DATA_W=32 → illegal.
- Load extraction: lanes are selected at offset and extended to DATA_W.
- Load latency: a request in cycle N drives rd and rd_valid=1 in cycle N+1. rd then holds its value until the next completed load.
- Ordering: a store in cycle N followed by a load of the same bytes in cycle N+1 returns the new data. No same-cycle read/write conflict exists because of the priority rule.
- Alignment: an access of size s requires a mod s = 0. On violation:
  - no array write occurs;
  - rd is unchanged and rd_valid=0;
  - misaligned=1 in cycle N+1.
- Illegal Funct3: no access occurs, illegal=1 in N+1, and misaligned=0. Illegal takes priority over the alignment check.
- Idle (MemRead=MemWrite=0): all pulses are 0 next cycle and rd holds.
- Back-to-back loads: one per cycle; rd_valid stays high continuously.
- Address wrap: none, because the address is fully decoded. For any legal aligned access, offset+size ≤ NB, so an access never crosses a word.
- Reset asserted mid-operation: pending pulses clear immediately, and a load issued in the reset cycle never produces rd_valid.

Test Plan:
- Store then load, DATA_W=32: SW a=0x10 wd=0x8081_8283, then LB a=0x10 → N+1 rd=0xFFFF_FF83, rd_valid=1. LBU a=0x13 → rd=0x0000_0080. LHU a=0x12 → rd=0x0000_8081. LH a=0x12 → rd=0xFFFF_8081.
- Byte-lane merge: SW a=0x20 wd=0; SB a=0x21 wd=0xAB; SH a=0x22 wd=0x1234; LW a=0x20 → rd=0x1234_AB00.
- Misaligned: SW a=0x22 → misaligned=1 next cycle, and LW a=0x20 still returns the prior contents. LH a=0x05 → misaligned=1, rd_valid=0, rd unchanged.
- Illegal/priority: load with Funct3=111 → illegal=1, misaligned=0. MemRead=MemWrite=1 SW a=0x30 wd=0x5 → rd_valid=0, then LW a=0x30 → rd=0x5.
- DATA_W=64: SD a=0x08 wd=0xF000_0000_8000_0001; LW a=0x08 → rd=0xFFFF_FFFF_8000_0001; LWU a=0x08 → rd=0x0000_0000_8000_0001; LD a=0x0C → misaligned=1.
- Reset: issue LW, assert rst_n=0 before the next edge → rd=0 and rd_valid=0 immediately. SW issued while rst_n=0 leaves the target word unchanged.

Source files
------------

// File: rtl/datamem_lanes.sv
// datamem_lanes: byte-lane data memory with RISC-V load extension, registered read data and error pulses
module datamem_lanes #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  MemRead,
    input  logic                  MemWrite,
    input  logic [DM_ADDRESS-1:0] a,
    input  logic [DATA_W-1:0]     wd,
    input  logic [2:0]            Funct3,
    output logic [DATA_W-1:0]     rd,
    output logic                  rd_valid,
    output logic                  misaligned,
    output logic                  illegal
);
    localparam int NB    = DATA_W / 8;
    localparam int OFF   = $clog2(NB);
    localparam int DEPTH = 1 << (DM_ADDRESS - OFF);
    localparam bit W64   = (DATA_W == 64);

    logic [DATA_W-1:0]         mem [DEPTH];
    logic [DM_ADDRESS-OFF-1:0] idx;
    logic [OFF-1:0]            off;
    logic [1:0]                sz;
    logic [NB-1:0]             be;
    logic [DATA_W-1:0]         wdata, word, keep, top, ext;
    logic                      st_ok, ld_ok, legal, aligned, access, do_wr, do_rd, sgn;
    logic [DATA_W-1:0]         rd_d, rd_q;
    logic                      rd_valid_d, rd_valid_q, mis_d, mis_q, ill_d, ill_q;

    // Decode size/legality/alignment, build lane enables and extend the selected load lanes
    always_comb begin
        idx        = a[DM_ADDRESS-1:OFF];
        off        = a[OFF-1:0];
        sz         = Funct3[1:0];
        sgn        = ~Funct3[2];
        st_ok      = ~Funct3[2] && (W64 || sz != 2'b11);
        ld_ok      = W64 ? (Funct3 != 3'b111) : (sz != 2'b11 && Funct3 != 3'b110);
        legal      = MemWrite ? st_ok : ld_ok;
        access     = MemWrite | MemRead;
        aligned    = (off & OFF'((1 << sz) - 1)) == '0;
        do_wr      = MemWrite & legal & aligned;
        do_rd      = ~MemWrite & MemRead & legal & aligned;
        be         = NB'((1 << (1 << sz)) - 1) << off;
        wdata      = wd << {off, 3'b000};
        word       = mem[idx] >> {off, 3'b000};
        keep       = (sz == 2'd0) ? DATA_W'(8'hFF) :
                     (sz == 2'd1) ? DATA_W'(16'hFFFF) :
                     (sz == 2'd2) ? DATA_W'(32'hFFFF_FFFF) : '1;
        top        = keep & ~(keep >> 1);
        ext        = (word & keep) | ({DATA_W{sgn & |(word & top)}} & ~keep);
        rd_d       = do_rd ? ext : rd_q;
        rd_valid_d = do_rd;
        ill_d      = access & ~legal;
        mis_d      = access & legal & ~aligned;
    end

    // Byte-enabled array write; suppressed while reset is held
    always_ff @(posedge clk) begin
        if (rst_n && do_wr)
            for (int i = 0; i < NB; i++)
                if (be[i]) mem[idx][i*8 +: 8] <= wdata[i*8 +: 8];
    end

    // Registered load result and one-cycle status pulses
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q       <= '0;
            rd_valid_q <= 1'b0;
            mis_q      <= 1'b0;
            ill_q      <= 1'b0;
        end else begin
            rd_q       <= rd_d;
            rd_valid_q <= rd_valid_d;
            mis_q      <= mis_d;
            ill_q      <= ill_d;
        end
    end

    assign rd         = rd_q;
    assign rd_valid   = rd_valid_q;
    assign misaligned = mis_q;
    assign illegal    = ill_q;
endmodule

// File: tb/tb_datamem_lanes.sv
// tb_datamem_lanes: checks 32- and 64-bit instances against a byte-addressed reference model
module tb_datamem_lanes;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        mr = 1'b0, mw = 1'b0;
    logic [2:0]  f3 = '0;
    logic [8:0]  addr = '0;
    logic [63:0] wd = '0;
    logic [31:0] rd32;
    logic [63:0] rd64;
    logic        v32, v64, mis32, mis64, ill32, ill64;
    int          checks = 0, failures = 0;
    bit          chk_en = 1'b0;

    logic [7:0]  mm [2][512];
    logic [63:0] e_rd [2];
    logic        e_v [2], e_mis [2], e_ill [2];

    always #5 clk = ~clk;

    datamem_lanes #(.DM_ADDRESS(9), .DATA_W(32)) u32 (
        .clk(clk), .rst_n(rst_n), .MemRead(mr), .MemWrite(mw), .a(addr), .wd(wd[31:0]),
        .Funct3(f3), .rd(rd32), .rd_valid(v32), .misaligned(mis32), .illegal(ill32)
    );
    datamem_lanes #(.DM_ADDRESS(9), .DATA_W(64)) u64 (
        .clk(clk), .rst_n(rst_n), .MemRead(mr), .MemWrite(mw), .a(addr), .wd(wd),
        .Funct3(f3), .rd(rd64), .rd_valid(v64), .misaligned(mis64), .illegal(ill64)
    );

    task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference: a flat byte array addressed directly, sizes taken from the Funct3 table
    task automatic model_step(input int k);
        int          w, sz;
        logic        ok;
        logic [63:0] v;
        w = k ? 64 : 32;
        case (f3)
            3'd0, 3'd4: sz = 1;
            3'd1, 3'd5: sz = 2;
            3'd2, 3'd6: sz = 4;
            default:    sz = 8;
        endcase
        ok = mw ? (f3 <= 3'd2 || (f3 == 3'd3 && w == 64))
                : (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5} || (w == 64 && (f3 == 3'd3 || f3 == 3'd6)));
        e_v[k] = 1'b0;
        e_mis[k] = 1'b0;
        e_ill[k] = 1'b0;
        if (!(mr || mw)) return;
        if (!ok) e_ill[k] = 1'b1;
        else if (int'(addr) % sz != 0) e_mis[k] = 1'b1;
        else if (mw) begin
            for (int i = 0; i < sz; i++) mm[k][int'(addr) + i] = wd[8*i +: 8];
        end else begin
            v = '0;
            for (int i = 0; i < sz; i++) v |= 64'(mm[k][int'(addr) + i]) << (8 * i);
            if (f3 < 3'd4 && sz < 8 && v[8*sz-1]) v |= ~64'd0 << (8 * sz);
            e_rd[k] = (w == 32) ? (v & 64'hFFFF_FFFF) : v;
            e_v[k] = 1'b1;
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 2; k++) begin
                e_rd[k] = '0;
                e_v[k] = 1'b0;
                e_mis[k] = 1'b0;
                e_ill[k] = 1'b0;
            end
        end else begin
            model_step(0);
            model_step(1);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            cmp("rd32", {32'd0, rd32}, e_rd[0]);
            cmp("rd_valid32", 64'(v32), 64'(e_v[0]));
            cmp("misaligned32", 64'(mis32), 64'(e_mis[0]));
            cmp("illegal32", 64'(ill32), 64'(e_ill[0]));
            cmp("rd64", rd64, e_rd[1]);
            cmp("rd_valid64", 64'(v64), 64'(e_v[1]));
            cmp("misaligned64", 64'(mis64), 64'(e_mis[1]));
            cmp("illegal64", 64'(ill64), 64'(e_ill[1]));
        end
    end

    task automatic op(input logic r, input logic w, input logic [2:0] f, input logic [8:0] ad, input logic [63:0] d);
        mr = r; mw = w; f3 = f; addr = ad; wd = d;
        @(negedge clk);
        mr = 1'b0; mw = 1'b0;
    endtask

    initial begin
        @(posedge clk);
        chk_en = 1'b1;
        @(negedge clk);
        cmp("reset_rd32", {32'd0, rd32}, 64'd0);
        cmp("reset_valid", 64'(v32 | mis32 | ill32), 64'd0);
        rst_n = 1'b1;
        op(0, 1, 3'd2, 9'h010, 64'h8081_8283);
        op(1, 0, 3'd0, 9'h010, 0);
        cmp("lb32", {32'd0, rd32}, 64'hFFFF_FF83);
        cmp("lb64", rd64, 64'hFFFF_FFFF_FFFF_FF83);
        cmp("lb_valid", 64'(v32), 64'd1);
        op(1, 0, 3'd4, 9'h013, 0);
        cmp("lbu32", {32'd0, rd32}, 64'h0000_0080);
        op(1, 0, 3'd5, 9'h012, 0);
        cmp("lhu32", {32'd0, rd32}, 64'h0000_8081);
        op(1, 0, 3'd1, 9'h012, 0);
        cmp("lh32", {32'd0, rd32}, 64'hFFFF_8081);
        cmp("lh64", rd64, 64'hFFFF_FFFF_FFFF_8081);
        op(0, 1, 3'd2, 9'h020, 0);
        op(0, 1, 3'd0, 9'h021, 64'hAB);
        op(0, 1, 3'd1, 9'h022, 64'h1234);
        op(1, 0, 3'd2, 9'h020, 0);
        cmp("merge32", {32'd0, rd32}, 64'h1234_AB00);
        op(0, 1, 3'd2, 9'h022, 64'hFFFF_FFFF);
        cmp("sw_mis32", 64'(mis32), 64'd1);
        op(1, 0, 3'd2, 9'h020, 0);
        cmp("after_mis32", {32'd0, rd32}, 64'h1234_AB00);
        op(1, 0, 3'd1, 9'h005, 0);
        cmp("lh_mis32", 64'(mis32), 64'd1);
        cmp("lh_mis_valid", 64'(v32), 64'd0);
        cmp("lh_mis_hold", {32'd0, rd32}, 64'h1234_AB00);
        op(1, 0, 3'd7, 9'h020, 0);
        cmp("ill32", 64'(ill32), 64'd1);
        cmp("ill_nomis", 64'(mis32), 64'd0);
        op(1, 1, 3'd2, 9'h030, 64'h5);
        cmp("prio_valid", 64'(v32), 64'd0);
        op(1, 0, 3'd2, 9'h030, 0);
        cmp("prio_rd", {32'd0, rd32}, 64'h5);
        op(0, 1, 3'd2, 9'h008, 64'h1122_3344);
        op(0, 1, 3'd2, 9'h00C, 64'h5566_7788);
        op(0, 1, 3'd3, 9'h008, 64'hF000_0000_8000_0001);
        cmp("sd_ill32", 64'(ill32), 64'd1);
        op(1, 0, 3'd2, 9'h008, 0);
        cmp("lw64", rd64, 64'hFFFF_FFFF_8000_0001);
        cmp("lw32_sd", {32'd0, rd32}, 64'h1122_3344);
        op(1, 0, 3'd6, 9'h008, 0);
        cmp("lwu64", rd64, 64'h0000_0000_8000_0001);
        op(1, 0, 3'd3, 9'h00C, 0);
        cmp("ld_mis64", 64'(mis64), 64'd1);
        op(1, 0, 3'd3, 9'h008, 0);
        cmp("ld64", rd64, 64'hF000_0000_8000_0001);
        op(1, 0, 3'd2, 9'h010, 0);
        mr = 1'b1; f3 = 3'd2; addr = 9'h020;
        #2 rst_n = 1'b0;
        #1;
        cmp("async_rd", {32'd0, rd32}, 64'd0);
        cmp("async_valid", 64'(v32 | v64), 64'd0);
        mr = 1'b0; mw = 1'b1; f3 = 3'd2; addr = 9'h010; wd = 64'hDEAD_BEEF;
        @(negedge clk);
        mw = 1'b0;
        rst_n = 1'b1;
        op(1, 0, 3'd2, 9'h010, 0);
        cmp("rst_nowrite", {32'd0, rd32}, 64'hFFFF_FFFF_8081_8283 & 64'hFFFF_FFFF);
        op(0, 0, 3'd0, 9'h000, 0);
        op(0, 0, 3'd0, 9'h000, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
